uart_rx: RTL and testbench

//  8N1 UART receiver; the receive half of the MMIO UART, paired with uart_tx on the same baud settings.

---
 rtl/uart_pkg.sv | 10 +
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_rx.sv | 139 +++++++++++++
 tb/tb_uart_rx.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and baud arithmetic. The receiver uses them today, and the transmitter can move its state type here later.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;

  function automatic int clk_per_bit(input int clock_hz, input int baud_rate);
    return clock_hz / baud_rate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, with a 2-cycle latency.
// It has no backpressure. Its reset value is chosen with RST_VAL.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      meta <= RST_VAL;
      o_q  <= RST_VAL;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling. A byte appears about 2+CLK_PER_BIT/2+9*CLK_PER_BIT cycles after the start edge.
// Bytes are held in a one-entry valid/ack register. A byte that arrives while it is still full is dropped and flags o_overrun.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_HZ  = 50_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_uart_rx,
  input  logic       i_ack,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int CPB = clk_per_bit(CLOCK_HZ, BAUD_RATE);
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] CB = CW'(CPB - 1);
  localparam logic [CW-1:0] HB = CW'(CPB / 2 - 1);

  logic           rx_s;
  uart_rx_state_t state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [2:0]     bit_idx, bit_idx_nxt;
  logic [7:0]     shreg, shreg_nxt;
  logic           accept, frame_err;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_uart_rx),
    .o_q     (rx_s)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    accept      = 1'b0;
    frame_err   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (cnt == HB) begin
          cnt_nxt = '0;
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            bit_idx_nxt = '0;
            state_nxt   = DATA;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CB) begin
          cnt_nxt   = '0;
          shreg_nxt = {rx_s, shreg[7:1]};
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 bit_idx_nxt = bit_idx + 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STOP: begin
        // Leave at stop-bit centre so a start bit that follows immediately is still caught.
        if (cnt == CB) begin
          cnt_nxt = '0;
          if (rx_s) begin
            accept    = 1'b1;
            state_nxt = IDLE;
          end else begin
            frame_err = 1'b1;
            state_nxt = BREAK;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      BREAK: begin
        cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign o_busy = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= frame_err;
      if (accept) begin
        if (!o_valid || i_ack) begin
          o_data  <= shreg;
          o_valid <= 1'b1;
          if (i_ack) o_overrun <= 1'b0;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (i_ack && o_valid) begin
        o_valid   <= 1'b0;
        o_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit. A serial driver task plays the transmitter.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n, rx, ack;
  logic [7:0] data;
  logic       valid, ferr, ovr, busy;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, start_cyc = 0, rise_cyc = 0, ferr_cyc = 0;
  logic vld_q = 1'b0;

  uart_rx #(.CLOCK_HZ(16), .BAUD_RATE(1)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_uart_rx   (rx),
    .i_ack       (ack),
    .o_data      (data),
    .o_valid     (valid),
    .o_frame_err (ferr),
    .o_overrun   (ovr),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid && !vld_q) rise_cyc = cyc;
    vld_q = valid;
    if (ferr) ferr_cyc++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_valid(input string nm, input int lim);
    int n = 0;
    while (!valid && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(valid), 32'd1);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  // Call this at a negedge. ack_at and rst_at are frame-relative cycle numbers, and -1 disables each of them.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int ack_at, input int rst_at);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    start_cyc = cyc;
    for (int k = 0; k < 160; k++) begin
      rx  = bits[k/16];
      ack = (k == ack_at);
      if (k == rst_at) rst_n = 1'b0;
      else if (k == rst_at + 2) rst_n = 1'b1;
      @(negedge clk);
    end
    rx  = 1'b1;
    ack = 1'b0;
  endtask

  typedef struct {
    logic [7:0] dat;
    logic       stop;
    int         hold_low;
    logic       do_ack;
    logic       exp_vld;
    logic [7:0] exp_dat;
    logic       exp_ovr;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int f0, lat;
    logic [7:0] b;

    vecs[0] = '{8'hA5, 1'b1, 0,  1'b1, 1'b1, 8'hA5, 1'b0, 0};
    vecs[1] = '{8'h3C, 1'b0, 0,  1'b0, 1'b0, 8'hA5, 1'b0, 1};
    vecs[2] = '{8'h81, 1'b1, 0,  1'b1, 1'b1, 8'h81, 1'b0, 0};
    vecs[3] = '{8'h11, 1'b1, 0,  1'b0, 1'b1, 8'h11, 1'b0, 0};
    vecs[4] = '{8'h22, 1'b1, 0,  1'b1, 1'b1, 8'h11, 1'b1, 0};
    vecs[5] = '{8'h00, 1'b0, 64, 1'b0, 1'b0, 8'h11, 1'b0, 1};

    rst_n = 1'b0; rx = 1'b1; ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data",  32'(data),  32'd0);
    check("rst_ferr",  32'(ferr),  32'd0);
    check("rst_ovr",   32'(ovr),   32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      f0 = ferr_cyc;
      send_frame(vecs[i].dat, vecs[i].stop, -1, -1);
      if (vecs[i].hold_low > 0) begin
        rx = 1'b0;
        repeat (vecs[i].hold_low) @(negedge clk);
        rx = 1'b1;
      end
      if (i == 0) begin
        lat = rise_cyc - start_cyc;
        check("latency_in_153_155", 32'(lat >= 153 && lat <= 155), 32'd1);
      end
      repeat (20) @(negedge clk);
      if (vecs[i].exp_vld) wait_valid("vec_valid_wait", 8);
      check("vec_valid", 32'(valid), 32'(vecs[i].exp_vld));
      check("vec_data",  32'(data),  32'(vecs[i].exp_dat));
      check("vec_ovr",   32'(ovr),   32'(vecs[i].exp_ovr));
      check("vec_ferr_cycles", 32'(ferr_cyc - f0), 32'(vecs[i].exp_ferr));
      check("vec_busy_idle", 32'(busy), 32'd0);
      if (vecs[i].do_ack) begin
        pulse_ack();
        check("ack_valid_clr", 32'(valid), 32'd0);
        check("ack_ovr_clr",   32'(ovr),   32'd0);
      end
    end

    // A 4-cycle low glitch is rejected at the half-bit check.
    f0 = ferr_cyc;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy_hi", 32'(busy), 32'd1);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_busy_lo", 32'(busy), 32'd0);
    check("glitch_valid",   32'(valid), 32'd0);
    check("glitch_ferr",    32'(ferr_cyc - f0), 32'd0);

    // Back-to-back frames, with ack raised on the second frame's accept cycle.
    send_frame(8'h55, 1'b1, -1, -1);
    send_frame(8'hAA, 1'b1, 154, -1);
    check("b2b_valid", 32'(valid), 32'd1);
    check("b2b_data",  32'(data),  32'hAA);
    check("b2b_ovr",   32'(ovr),   32'd0);
    pulse_ack();
    repeat (4) @(negedge clk);

    // Reset during data bit 4. The tail bits are all 1, so no false start follows.
    send_frame(8'hF0, 1'b1, -1, 88);
    repeat (4) @(negedge clk);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_data",  32'(data),  32'd0);
    send_frame(8'h7E, 1'b1, -1, -1);
    wait_valid("post_rst_wait", 8);
    check("post_rst_data", 32'(data), 32'h7E);
    pulse_ack();

    for (int i = 0; i < 258; i++) begin
      b = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, -1, -1);
      wait_valid("loop_wait", 8);
      check("loop_data", 32'(data), 32'(b));
      pulse_ack();
    end
    check("loop_ovr", 32'(ovr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
